// File: rtl/sa_autosa_cmac_reg_pkg.sv
// CMAC register bank shared definitions:
// register offsets and field bit positions.
package sa_autosa_cmac_reg_pkg;

  localparam logic [11:0] S_STATUS    = 12'h000;
  localparam logic [11:0] S_POINTER   = 12'h004;
  localparam logic [11:0] D_OP_ENABLE = 12'h008;
  localparam logic [11:0] D_MISC_CFG  = 12'h00C;

  localparam int STAT_LOCK_ERR_BIT = 16;
  localparam int STAT_DONE_ERR_BIT = 17;
  localparam int CONS_LSB          = 16;
  localparam int PREC_LSB          = 12;
  localparam int COSA_BIT          = 0;
  localparam int OP_EN_BIT         = 0;

endpackage

// File: rtl/sa_autosa_cmac_reg_group.sv
// One CMAC register group: op_en, cosa_mode, proc_precision.
// In: clk, rst, set_op_en, clr_op_en, cfg_wr, wr_data. Out: group fields.
module sa_autosa_cmac_reg_group
  import sa_autosa_cmac_reg_pkg::*;
#(
  parameter int PREC_W     = 2,
  parameter int PREC_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_op_en,
  input  logic              clr_op_en,
  input  logic              cfg_wr,
  input  logic [31:0]       wr_data,
  output logic              op_en,
  output logic              cosa_mode,
  output logic [PREC_W-1:0] proc_precision
);

  logic              op_en_q, op_en_d;
  logic              cosa_q, cosa_d;
  logic [PREC_W-1:0] prec_q, prec_d;
  logic              unused_wr;

  assign unused_wr = ^wr_data;

  always_comb begin
    op_en_d = op_en_q;
    cosa_d  = cosa_q;
    prec_d  = prec_q;
    if (cfg_wr) begin
      cosa_d = wr_data[COSA_BIT];
      prec_d = wr_data[PREC_LSB +: PREC_W];
    end
    if (set_op_en) op_en_d = 1'b1;
    // completion wins; set is only issued to unlocked groups
    if (clr_op_en) op_en_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_en_q <= 1'b0;
      cosa_q  <= 1'b0;
      prec_q  <= PREC_W'(PREC_RESET);
    end else begin
      op_en_q <= op_en_d;
      cosa_q  <= cosa_d;
      prec_q  <= prec_d;
    end
  end

  assign op_en          = op_en_q;
  assign cosa_mode      = cosa_q;
  assign proc_precision = prec_q;

endmodule

// File: rtl/sa_autosa_cmac_reg_bank.sv
// CMAC ping-pong register bank: CSB reg write/read in, consumer group
// fields (core_*) out, core_done in, op_done/op_en_trigger pulses out.
module sa_autosa_cmac_reg_bank
  import sa_autosa_cmac_reg_pkg::*;
#(
  parameter int NUM_GROUPS = 2,
  parameter int PREC_W     = 2,
  parameter int PREC_RESET = 1
) (
  input  logic                          autosa_core_clk,
  input  logic                          autosa_core_rst,
  input  logic [11:0]                   reg_offset,
  input  logic [31:0]                   reg_wr_data,
  input  logic                          reg_wr_en,
  output logic [31:0]                   reg_rd_data,
  output logic                          op_en_trigger,
  output logic                          core_op_en,
  output logic [$clog2(NUM_GROUPS)-1:0] core_group,
  output logic                          core_cosa_mode,
  output logic [PREC_W-1:0]             core_proc_precision,
  input  logic                          core_done,
  output logic                          op_done
);

  localparam int PTR_W = $clog2(NUM_GROUPS);

  logic                  wr_status, wr_ptr;
  logic                  wr_open, wr_cfg;
  logic [NUM_GROUPS-1:0] op_en_v, cosa_v;
  logic [NUM_GROUPS-1:0] set_v, clr_v, cfg_v;
  logic [PREC_W-1:0]     prec_a [NUM_GROUPS];
  logic [PTR_W-1:0]      prod_q, prod_d;
  logic [PTR_W-1:0]      cons_q, cons_d;
  logic                  lock_err_q, lock_err_d;
  logic                  done_err_q, done_err_d;
  logic                  op_done_q, op_done_d;
  logic                  prod_locked, done_ok;

  always_comb begin
    wr_status = 1'b0;
    wr_ptr    = 1'b0;
    wr_open   = 1'b0;
    wr_cfg    = 1'b0;
    if (reg_wr_en) begin
      case (reg_offset)
        S_STATUS:    wr_status = 1'b1;
        S_POINTER:   wr_ptr    = 1'b1;
        D_OP_ENABLE: wr_open   = 1'b1;
        D_MISC_CFG:  wr_cfg    = 1'b1;
        default:     ;
      endcase
    end
  end

  // lock is judged on pre-edge state, so a same-cycle
  // completion does not unlock the group for this write
  assign prod_locked = op_en_v[prod_q];
  assign done_ok     = core_done & op_en_v[cons_q];

  always_comb begin
    set_v = '0;
    clr_v = '0;
    cfg_v = '0;
    if (wr_open && reg_wr_data[OP_EN_BIT] && !prod_locked)
      set_v[prod_q] = 1'b1;
    if (wr_cfg && !prod_locked)
      cfg_v[prod_q] = 1'b1;
    if (done_ok)
      clr_v[cons_q] = 1'b1;
  end

  assign op_en_trigger = |set_v;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    sa_autosa_cmac_reg_group #(
      .PREC_W    (PREC_W),
      .PREC_RESET(PREC_RESET)
    ) u_grp (
      .clk           (autosa_core_clk),
      .rst           (autosa_core_rst),
      .set_op_en     (set_v[g]),
      .clr_op_en     (clr_v[g]),
      .cfg_wr        (cfg_v[g]),
      .wr_data       (reg_wr_data),
      .op_en         (op_en_v[g]),
      .cosa_mode     (cosa_v[g]),
      .proc_precision(prec_a[g])
    );
  end

  always_comb begin
    prod_d     = prod_q;
    cons_d     = cons_q;
    lock_err_d = lock_err_q;
    done_err_d = done_err_q;
    op_done_d  = done_ok;
    if (wr_ptr) prod_d = reg_wr_data[PTR_W-1:0];
    // power-of-two group count: natural overflow wraps
    if (done_ok) cons_d = cons_q + PTR_W'(1);
    if (wr_status && reg_wr_data[STAT_LOCK_ERR_BIT])
      lock_err_d = 1'b0;
    if (wr_status && reg_wr_data[STAT_DONE_ERR_BIT])
      done_err_d = 1'b0;
    // new events override a same-cycle clear
    if (wr_cfg && prod_locked) lock_err_d = 1'b1;
    if (core_done && !op_en_v[cons_q]) done_err_d = 1'b1;
  end

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      prod_q     <= '0;
      cons_q     <= '0;
      lock_err_q <= 1'b0;
      done_err_q <= 1'b0;
      op_done_q  <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      cons_q     <= cons_d;
      lock_err_q <= lock_err_d;
      done_err_q <= done_err_d;
      op_done_q  <= op_done_d;
    end
  end

  always_comb begin
    reg_rd_data = '0;
    case (reg_offset)
      S_STATUS: begin
        reg_rd_data[NUM_GROUPS-1:0]    = op_en_v;
        reg_rd_data[STAT_LOCK_ERR_BIT] = lock_err_q;
        reg_rd_data[STAT_DONE_ERR_BIT] = done_err_q;
      end
      S_POINTER: begin
        reg_rd_data[PTR_W-1:0]        = prod_q;
        reg_rd_data[CONS_LSB +: PTR_W] = cons_q;
      end
      D_OP_ENABLE:
        reg_rd_data[OP_EN_BIT] = op_en_v[prod_q];
      D_MISC_CFG: begin
        reg_rd_data[COSA_BIT]          = cosa_v[prod_q];
        reg_rd_data[PREC_LSB +: PREC_W] = prec_a[prod_q];
      end
      default: ;
    endcase
  end

  assign core_op_en          = op_en_v[cons_q];
  assign core_group          = cons_q;
  assign core_cosa_mode      = cosa_v[cons_q];
  assign core_proc_precision = prec_a[cons_q];
  assign op_done             = op_done_q;

endmodule
